// File: rtl/i3c_dat_mem_arbiter.sv
// rtl/i3c_dat_mem_arbiter.sv - shares the single-port DAT memory between CSR port A and lookup port B
// Optional build macro I3C_DAT_ARB_RR_EN selects round-robin instead of fixed B>A priority.
module i3c_dat_mem_arbiter #(
    parameter int unsigned AddrWidth = 5,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned MaxWait   = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,

    input  logic                 a_req_i,
    output logic                 a_gnt_o,
    input  logic                 a_write_i,
    input  logic [AddrWidth-1:0] a_addr_i,
    input  logic [DataWidth-1:0] a_wdata_i,
    input  logic [DataWidth-1:0] a_wmask_i,
    output logic                 a_rvalid_o,
    output logic [DataWidth-1:0] a_rdata_o,

    input  logic                 b_req_i,
    output logic                 b_gnt_o,
    input  logic                 b_write_i,
    input  logic [AddrWidth-1:0] b_addr_i,
    input  logic [DataWidth-1:0] b_wdata_i,
    input  logic [DataWidth-1:0] b_wmask_i,
    output logic                 b_rvalid_o,
    output logic [DataWidth-1:0] b_rdata_o,

    output logic                 mem_req_o,
    output logic                 mem_write_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [DataWidth-1:0] mem_wdata_o,
    output logic [DataWidth-1:0] mem_wmask_o,
    input  logic [DataWidth-1:0] mem_rdata_i,
    input  logic                 mem_rvalid_i
);

    // Requests are masked during reset so grants and the memory port stay quiet.
    logic a_live;
    logic b_live;
    logic a_win;
    logic b_win;

    assign a_live = a_req_i & rst_ni;
    assign b_live = b_req_i & rst_ni;

`ifdef I3C_DAT_ARB_RR_EN
    // rr_q = 0: A wins the next contention; flips to the loser after each contention.
    logic rr_q;

    assign a_win = a_live & (~b_live | ~rr_q);
    assign b_win = b_live & ~a_win;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q <= 1'b0;
        end else if (a_live && b_live) begin
            rr_q <= a_win;
        end
    end
`else
    localparam int unsigned WaitW = $clog2(MaxWait + 1);
    localparam logic [WaitW-1:0] WaitMax = WaitW'(MaxWait);

    logic [WaitW-1:0] wait_cnt_q;
    logic             a_starved;

    assign a_starved = (wait_cnt_q == WaitMax);
    assign a_win     = a_live & (~b_live | a_starved);
    assign b_win     = b_live & ~a_win;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_cnt_q <= '0;
        end else if (!a_live || a_win) begin
            wait_cnt_q <= '0;
        end else if (!a_starved) begin
            wait_cnt_q <= wait_cnt_q + WaitW'(1);
        end
    end
`endif

    assign a_gnt_o   = a_win;
    assign b_gnt_o   = b_win;
    assign mem_req_o = a_win | b_win;

    always_comb begin
        mem_write_o = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_wmask_o = '0;
        if (a_win) begin
            mem_write_o = a_write_i;
            mem_addr_o  = a_addr_i;
            mem_wdata_o = a_wdata_i;
            mem_wmask_o = a_wmask_i;
        end else if (b_win) begin
            mem_write_o = b_write_i;
            mem_addr_o  = b_addr_i;
            mem_wdata_o = b_wdata_i;
            mem_wmask_o = b_wmask_i;
        end
    end

    // One-deep read tag: the memory returns exactly one cycle after the request,
    // so a new tag can be written every cycle while the previous one is consumed.
    logic rd_tag_valid_q;
    logic rd_tag_owner_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_tag_valid_q <= 1'b0;
            rd_tag_owner_q <= 1'b0;
        end else begin
            rd_tag_valid_q <= mem_req_o & ~mem_write_o;
            rd_tag_owner_q <= b_win;
        end
    end

    logic rd_return;
    assign rd_return  = mem_rvalid_i & rd_tag_valid_q;
    assign a_rvalid_o = rd_return & ~rd_tag_owner_q;
    assign b_rvalid_o = rd_return &  rd_tag_owner_q;

    logic [DataWidth-1:0] a_rdata_q;
    logic [DataWidth-1:0] b_rdata_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            if (a_rvalid_o) a_rdata_q <= mem_rdata_i;
            if (b_rvalid_o) b_rdata_q <= mem_rdata_i;
        end
    end

    // Return data passes straight through in the return cycle, then is held.
    assign a_rdata_o = a_rvalid_o ? mem_rdata_i : a_rdata_q;
    assign b_rdata_o = b_rvalid_o ? mem_rdata_i : b_rdata_q;

endmodule

// File: tb/tb_i3c_dat_mem_arbiter.sv
// tb/tb_i3c_dat_mem_arbiter.sv - self-checking bench for i3c_dat_mem_arbiter
// Optional build macro I3C_DAT_ARB_RR_EN selects the round-robin expectations.
module tb_i3c_dat_mem_arbiter;
    localparam int AW = 5;
    localparam int DW = 64;
    localparam int MW = 4;
    localparam int NW = 1 << AW;
`ifdef I3C_DAT_ARB_RR_EN
    localparam bit RR = 1'b1;
    localparam int A_LAT = 2;
`else
    localparam bit RR = 1'b0;
    localparam int A_LAT = MW + 1;
`endif
    localparam int B_LAT = 2;

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] wmask;
    } txn_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          a_req_i = 1'b0, a_write_i = 1'b0, b_req_i = 1'b0, b_write_i = 1'b0;
    logic [AW-1:0] a_addr_i = '0, b_addr_i = '0;
    logic [DW-1:0] a_wdata_i = '0, a_wmask_i = '0, b_wdata_i = '0, b_wmask_i = '0;
    logic          a_gnt_o, b_gnt_o, a_rvalid_o, b_rvalid_o;
    logic [DW-1:0] a_rdata_o, b_rdata_o;
    logic          mem_req_o, mem_write_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o, mem_wmask_o;
    logic [DW-1:0] mem_rdata_i = '0;
    logic          mem_rvalid_i = 1'b0;
    logic          inject_rv = 1'b0;

    int n_pass = 0;
    int n_checks = 0;

    txn_t aq[$];
    txn_t bq[$];
    int   glog[$];

    i3c_dat_mem_arbiter #(.AddrWidth(AW), .DataWidth(DW), .MaxWait(MW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .a_req_i(a_req_i), .a_gnt_o(a_gnt_o), .a_write_i(a_write_i), .a_addr_i(a_addr_i),
        .a_wdata_i(a_wdata_i), .a_wmask_i(a_wmask_i), .a_rvalid_o(a_rvalid_o), .a_rdata_o(a_rdata_o),
        .b_req_i(b_req_i), .b_gnt_o(b_gnt_o), .b_write_i(b_write_i), .b_addr_i(b_addr_i),
        .b_wdata_i(b_wdata_i), .b_wmask_i(b_wmask_i), .b_rvalid_o(b_rvalid_o), .b_rdata_o(b_rdata_o),
        .mem_req_o(mem_req_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
        .mem_rdata_i(mem_rdata_i), .mem_rvalid_i(mem_rvalid_i)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_word(input int i);
        return 64'hDEAD_BEEF_0000_0000 | 64'(i);
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    endtask

    // Memory device: one-cycle registered read, bit-masked write, reloaded in reset.
    logic [DW-1:0] phys [NW];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NW; i++) phys[i] <= init_word(i);
            mem_rvalid_i <= 1'b0;
        end else begin
            if (mem_req_o && mem_write_o)
                phys[mem_addr_o] <= (phys[mem_addr_o] & ~mem_wmask_o) | (mem_wdata_o & mem_wmask_o);
            mem_rvalid_i <= (mem_req_o && !mem_write_o) || inject_rv;
            mem_rdata_i  <= (mem_req_o && !mem_write_o) ? phys[mem_addr_o] : 64'h0BAD_0BAD_0BAD_0BAD;
        end
    end

    // Requesters present the head of their queue, holding it until the model pops it.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            a_req_i = (aq.size() > 0);
            if (a_req_i) begin
                a_write_i = aq[0].write; a_addr_i = aq[0].addr;
                a_wdata_i = aq[0].wdata; a_wmask_i = aq[0].wmask;
            end else begin
                a_write_i = 1'b0; a_addr_i = '0; a_wdata_i = '0; a_wmask_i = '0;
            end
            b_req_i = (bq.size() > 0);
            if (b_req_i) begin
                b_write_i = bq[0].write; b_addr_i = bq[0].addr;
                b_wdata_i = bq[0].wdata; b_wmask_i = bq[0].wmask;
            end else begin
                b_write_i = 1'b0; b_addr_i = '0; b_wdata_i = '0; b_wmask_i = '0;
            end
        end
    end

    // Reference model and per-cycle compare.
    logic [DW-1:0] ref_mem [NW];
    logic          pend_v, pend_own;
    logic [DW-1:0] pend_d, hold_a, hold_b;
    int            losses, a_age, b_age;
    logic          prefer_b;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_a_gnt", a_gnt_o, 0);      chk("rst_b_gnt", b_gnt_o, 0);
                chk("rst_a_rvalid", a_rvalid_o, 0); chk("rst_b_rvalid", b_rvalid_o, 0);
                chk("rst_a_rdata", a_rdata_o, 0);   chk("rst_b_rdata", b_rdata_o, 0);
                chk("rst_mem_req", mem_req_o, 0);   chk("rst_mem_write", mem_write_o, 0);
                chk("rst_mem_addr", mem_addr_o, 0); chk("rst_mem_wdata", mem_wdata_o, 0);
                chk("rst_mem_wmask", mem_wmask_o, 0);
                for (int i = 0; i < NW; i++) ref_mem[i] = init_word(i);
                pend_v = 0; pend_own = 0; pend_d = 0; hold_a = 0; hold_b = 0;
                losses = 0; a_age = 0; b_age = 0; prefer_b = 0;
            end else begin
                logic ea, eb, era, erb;
                txn_t t;
                if (RR) ea = a_req_i && (!b_req_i || !prefer_b);
                else    ea = a_req_i && (!b_req_i || losses >= MW);
                eb = b_req_i && !ea;
                chk("a_gnt", a_gnt_o, ea);
                chk("b_gnt", b_gnt_o, eb);
                chk("gnt_exclusive", a_gnt_o & b_gnt_o, 0);
                t = '{write: 1'b0, addr: '0, wdata: '0, wmask: '0};
                if (ea) t = aq[0];
                else if (eb) t = bq[0];
                chk("mem_req", mem_req_o, ea | eb);
                chk("mem_write", mem_write_o, t.write);
                chk("mem_addr", mem_addr_o, t.addr);
                chk("mem_wdata", mem_wdata_o, t.wdata);
                chk("mem_wmask", mem_wmask_o, t.wmask);
                era = pend_v && !pend_own;
                erb = pend_v && pend_own;
                if (era) hold_a = pend_d;
                if (erb) hold_b = pend_d;
                chk("a_rvalid", a_rvalid_o, era);
                chk("b_rvalid", b_rvalid_o, erb);
                chk("a_rdata", a_rdata_o, hold_a);
                chk("b_rdata", b_rdata_o, hold_b);
                pend_v = 0;
                if (ea || eb) begin
                    if (t.write) ref_mem[t.addr] = (ref_mem[t.addr] & ~t.wmask) | (t.wdata & t.wmask);
                    else begin
                        pend_v = 1; pend_own = eb; pend_d = ref_mem[t.addr];
                    end
                    glog.push_back(eb ? 1 : 0);
                    if (ea) void'(aq.pop_front());
                    else    void'(bq.pop_front());
                end
                if (a_req_i) begin
                    if (ea) begin chk("a_latency", a_age < A_LAT, 1); a_age = 0; end
                    else a_age++;
                end else a_age = 0;
                if (b_req_i) begin
                    if (eb) begin chk("b_latency", b_age < B_LAT, 1); b_age = 0; end
                    else b_age++;
                end else b_age = 0;
                if (a_req_i && b_req_i) prefer_b = ea;
                if (a_req_i && !ea) losses = (losses < MW) ? losses + 1 : MW;
                else losses = 0;
            end
        end
    end

    task automatic push_a(input logic w, input int addr, input logic [DW-1:0] d, input logic [DW-1:0] m);
        aq.push_back('{write: w, addr: AW'(addr), wdata: d, wmask: m});
    endtask
    task automatic push_b(input logic w, input int addr, input logic [DW-1:0] d, input logic [DW-1:0] m);
        bq.push_back('{write: w, addr: AW'(addr), wdata: d, wmask: m});
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while ((aq.size() > 0 || bq.size() > 0) && n < 500) begin
            @(posedge clk);
            n++;
        end
        chk(nm, n < 500, 1);
        repeat (3) @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int fixed_pat [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        int rr_pat [10]    = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
        int n;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #2;

        // A read addr 3 alone
        push_a(0, 3, 0, 0);
        wait_idle("idle_t1");
        chk("t1_a_rdata", a_rdata_o, 64'hDEAD_BEEF_0000_0003);
        chk("t1_b_rdata", b_rdata_o, 64'h0);

        // Continuous contention
        glog.delete();
        for (int i = 0; i < 10; i++) begin
            push_a(0, 10 + i, 0, 0);
            push_b(0, 20 + i, 0, 0);
        end
        wait_idle("idle_t2");
        chk("t2_grants", glog.size(), 20);
        if (glog.size() >= 10)
            for (int i = 0; i < 10; i++) chk($sformatf("t2_order_%0d", i), glog[i], RR ? rr_pat[i] : fixed_pat[i]);
        chk("t2_a_last", a_rdata_o, 64'hDEAD_BEEF_0000_0013);
        chk("t2_b_last", b_rdata_o, 64'hDEAD_BEEF_0000_001D);

        // Masked B write, then A read back
        push_b(1, 7, 64'h1, 64'h0000_0000_FFFF_FFFF);
        @(posedge clk); #2;
        push_a(0, 7, 0, 0);
        wait_idle("idle_t3");
        chk("t3_a_rdata", a_rdata_o, 64'hDEAD_BEEF_0000_0001);

        // Back-to-back reads from different owners
        push_a(0, 1, 0, 0);
        @(posedge clk); #2;
        push_b(0, 2, 0, 0);
        wait_idle("idle_t4");
        chk("t4_a_rdata", a_rdata_o, 64'hDEAD_BEEF_0000_0001);
        chk("t4_b_rdata", b_rdata_o, 64'hDEAD_BEEF_0000_0002);

        // Spurious memory valid without a tag
        inject_rv = 1'b1;
        @(posedge clk); #2;
        inject_rv = 1'b0;
        repeat (2) @(posedge clk); #2;

        // Reset the cycle after a granted read
        glog.delete();
        push_a(0, 5, 0, 0);
        n = 0;
        while (glog.size() == 0 && n < 20) begin @(posedge clk); n++; end
        chk("t5_grant_seen", n < 20, 1);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #2;
        push_a(0, 3, 0, 0);
        wait_idle("idle_t5");
        chk("t5_post_rst_rdata", a_rdata_o, 64'hDEAD_BEEF_0000_0003);

        // Random traffic against the reference model
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #2;
            if (aq.size() == 0 && $urandom_range(0, 2) != 0)
                push_a(1'($urandom_range(0, 1)), $urandom_range(0, 7), {$urandom, $urandom}, {$urandom, $urandom});
            if (bq.size() == 0 && $urandom_range(0, 2) != 0)
                push_b(1'($urandom_range(0, 1)), $urandom_range(0, 7), {$urandom, $urandom}, {$urandom, $urandom});
        end
        wait_idle("idle_rand");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
